uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer sitting directly downstream of uart_rx. Captures each byte

---
 rtl/uart_pkg.sv | 12 +
 rtl/strobe_edge_det.sv | 19 +
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART byte types and character constants.
// Imported by the receive-side buffer and the strobe detector.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  localparam uart_byte_t ASCII_LF = 8'h0A;
  localparam uart_byte_t ASCII_CR = 8'h0D;

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for valid strobes of any length.
// One rise pulse per low-to-high transition of in.
module strobe_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive FIFO behind uart_rx, one entry per valid assertion.
// Define UART_RX_FIFO_LINE_EN to build the complete-line counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter uart_byte_t LINE_TERM = ASCII_LF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   line_cnt,
  output logic                     line_avail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  uart_byte_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            push;
  logic            pop;
  logic            wr_en;
  logic            drop;
  uart_byte_t      head;

  strobe_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (rx_valid),
    .rise (push)
  );

  assign rd_valid = cnt_q != '0;
  assign full     = cnt_q == CW'(DEPTH);
  assign pop      = rd_valid & rd_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign head     = mem[rd_ptr];
  assign rd_data  = rd_valid ? head : '0;
  assign count    = cnt_q;
  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

`ifdef UART_RX_FIFO_LINE_EN
  logic [CW-1:0] lines_q;
  logic          term_in;
  logic          term_out;

  assign term_in  = wr_en & (rx_data == LINE_TERM);
  assign term_out = pop & (head == LINE_TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lines_q <= '0;
    end else begin
      unique case ({term_in, term_out})
        2'b10:   lines_q <= lines_q + CW'(1);
        2'b01:   lines_q <= lines_q - CW'(1);
        default: lines_q <= lines_q;
      endcase
    end
  end

  assign line_cnt   = lines_q;
  assign line_avail = lines_q != '0;
`else
  assign line_cnt   = '0;
  assign line_avail = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo.
// Model tracks the FIFO as a byte queue; monitor checks on negedge.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic [CW-1:0] line_cnt;
  logic          line_avail;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .LINE_TERM(8'h0A)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .line_cnt   (line_cnt),
    .line_avail (line_avail)
  );

  always #10 clk = ~clk;

  // Reference model: FIFO contents as a queue, plus sticky overflow.
  logic [7:0] mdl_q [$];
  logic [7:0] sb_q  [$];
  bit         mdl_ovf;
  bit         mdl_prev;
  bit         m_push;
  bit         m_pop;
  bit         m_acc;
  int         m_pre;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_q.delete();
      sb_q.delete();
      mdl_ovf  = 1'b0;
      mdl_prev = 1'b0;
    end else begin
      m_pre  = mdl_q.size();
      m_push = rx_valid && !mdl_prev;
      m_pop  = (m_pre != 0) && rd_ready;
      m_acc  = m_push && (m_pre < DEPTH || m_pop);
      if (m_pop) void'(mdl_q.pop_front());
      if (m_acc) begin
        mdl_q.push_back(rx_data);
        sb_q.push_back(rx_data);
      end
      if (m_push && !m_acc) mdl_ovf = 1'b1;
      else if (ovf_clr)     mdl_ovf = 1'b0;
      mdl_prev = rx_valid;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lines_in(input int unused);
    int n = 0;
`ifdef UART_RX_FIFO_LINE_EN
    foreach (mdl_q[i]) if (mdl_q[i] == 8'h0A) n++;
`endif
    return n + unused;
  endfunction

  // Monitor: state compares every cycle, data compares on each handshake.
  always @(negedge clk) begin
    int lines;
    lines = lines_in(0);
    chk("rd_valid", int'(rd_valid), int'(mdl_q.size() != 0));
    chk("count", int'(count), mdl_q.size());
    chk("full", int'(full), int'(mdl_q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(mdl_ovf));
    chk("line_cnt", int'(line_cnt), lines);
    chk("line_avail", int'(line_avail), int'(lines != 0));
    if (!rd_valid) chk("rd_data_empty", int'(rd_data), 0);
    if (rd_valid && rd_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("rd_data", int'(rd_data), int'(sb_q[0]));
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int len);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < len; k++) begin
      tick();
      rx_data = 8'($urandom);
    end
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hi [2];
    logic [7:0] ab [3];
    hi = '{8'h48, 8'h69};
    ab = '{8'h61, 8'h62, 8'h0A};
    #200;
    tick();
    rst = 1'b0;
    tick();

    foreach (hi[i]) send(hi[i], 1);
    repeat (3) tick();
    drain(2);
    repeat (2) tick();

    for (int i = 0; i <= 16; i++) send(8'(i), 1);
    repeat (2) tick();
    drain(20);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();

    send(8'hA5, 5);
    drain(3);

    for (int i = 0; i < DEPTH; i++) send(8'(i + 8'h30), 2);
    rd_ready = 1'b1;
    send(8'h55, 1);
    rd_ready = 1'b0;
    repeat (2) tick();
    drain(20);

    for (int i = 0; i < DEPTH; i++) send(8'(i), 1);
    ovf_clr = 1'b1;
    send(8'hEE, 1);
    ovf_clr = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    drain(20);

    foreach (ab[i]) send(ab[i], 1);
    tick();
    drain(5);

    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h7E;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rx_valid = 1'b0;
    repeat (2) tick();
    drain(3);

    for (int c = 0; c < 4000; c++) begin
      int bias;
      bias = ((c / 300) % 3 == 0) ? 15 : 60;
      rx_valid = $urandom_range(0, 99) < 45;
      rx_data  = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      rd_ready = $urandom_range(0, 99) < bias;
      ovf_clr  = $urandom_range(0, 99) < 4;
      tick();
    end
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    drain(DEPTH + 4);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
